// File: rtl/multiplication.sv
// -----------------------------------------------------------------------------
// multiplication
//   Sequential shift-and-add unsigned multiplier for the calculator datapath.
//   It uses the same go/done handshake and operand names as the restoring
//   divider, so the calculator top level can use either unit.
//   Operands are captured on start. One multiplier bit is retired per clock.
//   The full-width product is presented together with done.
//
// Parameters
//   WIDTH  operand width in bits; the product is 2*WIDTH bits
//
// Ports
//   clk   in   1        single clock, rising edge
//   rst   in   1        synchronous active-low reset
//   go    in   1        start request (level), sampled only in IDLE
//   x     in   WIDTH    multiplicand, unsigned
//   y     in   WIDTH    multiplier, unsigned
//   p     out  2*WIDTH  registered product x*y
//   busy  out  1        high while loading or iterating
//   done  out  1        high while the result is being presented
// -----------------------------------------------------------------------------
module multiplication #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic [2*WIDTH-1:0] p,
   output logic               busy,
   output logic               done
);

   // The counter must be able to hold WIDTH itself.
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StCalc = 2'd2,
      StDone = 2'd3
   } state_e;

   state_e             r_state;
   state_e             w_state_next;

   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mpr;
   logic [WIDTH-1:0]   r_mcand;
   logic [CNT_W-1:0]   r_count;
   logic [2*WIDTH-1:0] r_p;

   logic [WIDTH:0]     w_addend;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_shifted;
   logic               w_last;

   // ---------------------------------------------------------------------------
   // Datapath combinational terms
   // ---------------------------------------------------------------------------
   // The partial sum is WIDTH+1 bits wide, so the carry out of the add is kept.
   // The carry then shifts into the accumulator MSB.
   assign w_addend  = r_mpr[0] ? {1'b0, r_mcand} : '0;
   assign w_sum     = {1'b0, r_acc} + w_addend;
   // {sum, mpr} >> 1 with the vacated top bit dropped.
   assign w_shifted = {w_sum, r_mpr[WIDTH-1:1]};
   assign w_last    = (r_count == CNT_W'(1));

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (go) begin
               w_state_next = StLoad;
            end
         end
         StLoad: begin
            w_state_next = StCalc;
         end
         StCalc: begin
            // Always runs exactly WIDTH iterations; zero operands do not exit early.
            if (w_last) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            // go must be seen low before another start is accepted.
            if (!go) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc   <= '0;
         r_mpr   <= '0;
         r_mcand <= '0;
         r_count <= '0;
         r_p     <= '0;
      end else begin
         unique case (r_state)
            StLoad: begin
               r_mcand <= x;
               r_mpr   <= y;
               r_acc   <= '0;
               r_count <= CNT_W'(WIDTH);
            end
            StCalc: begin
               r_acc   <= w_shifted[2*WIDTH-1:WIDTH];
               r_mpr   <= w_shifted[WIDTH-1:0];
               r_count <= r_count - CNT_W'(1);
               // p only moves on the final iteration, so partial sums are never shown.
               if (w_last) begin
                  r_p <= w_shifted;
               end
            end
            default: begin
               // IDLE and DONE hold every datapath register.
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Both flags decode directly from the state register, so they are glitch-free.
   // They are also mutually exclusive.
   always_comb begin
      p    = r_p;
      busy = (r_state == StLoad) || (r_state == StCalc);
      done = (r_state == StDone);
   end

endmodule

// File: tb/tb_multiplication.sv
module tb_multiplication;

   localparam int unsigned WIDTH = 4;

   logic               clk;
   logic               rst;
   logic               go;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;
   logic [2*WIDTH-1:0] p;
   logic               busy;
   logic               done;

   int checks;
   int errors;

   logic [2*WIDTH-1:0] exp_p;

   multiplication #(
      .WIDTH(WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .go  (go),
      .x   (x),
      .y   (y),
      .p   (p),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // go is pulsed for one edge, then the run lasts exactly WIDTH+2 edges.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] prod);
      x  = a;
      y  = b;
      go = 1'b1;
      tick();                                   // edge 1: IDLE -> LOAD
      go = 1'b0;
      check({tag, " busy e1"}, 16'(busy), 16'd1);
      check({tag, " done e1"}, 16'(done), 16'd0);
      for (int e = 2; e <= 5; e++) begin
         tick();
         check({tag, " busy mid"}, 16'(busy), 16'd1);
         check({tag, " done mid"}, 16'(done), 16'd0);
         check({tag, " p held"}, 16'(p), 16'(exp_p));
      end
      tick();                                   // edge 6: CALC -> DONE
      exp_p = prod;
      check({tag, " done e6"}, 16'(done), 16'd1);
      check({tag, " busy e6"}, 16'(busy), 16'd0);
      check({tag, " p e6"}, 16'(p), 16'(exp_p));
      tick();                                   // go low seen in DONE
      check({tag, " done drop"}, 16'(done), 16'd0);
      check({tag, " busy idle"}, 16'(busy), 16'd0);
      check({tag, " p keep"}, 16'(p), 16'(exp_p));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_p  = '0;
      rst    = 1'b0;
      go     = 1'b0;
      x      = '0;
      y      = '0;

      // 1. reset
      tick();
      tick();
      check("rst p", 16'(p), 16'h00);
      check("rst done", 16'(done), 16'd0);
      check("rst busy", 16'(busy), 16'd0);
      rst = 1'b1;
      tick();
      check("idle busy", 16'(busy), 16'd0);

      // 2-4. basic products, max product, zero operands
      run_op("3x5", 4'd3, 4'd5, 8'h0F);
      run_op("FxF", 4'hF, 4'hF, 8'hE1);
      run_op("0x9", 4'd0, 4'd9, 8'h00);
      run_op("9x0", 4'd9, 4'd0, 8'h00);
      run_op("1xF", 4'd1, 4'hF, 8'h0F);

      // 5. go held high; operand changes during CALC are ignored
      x  = 4'd7;
      y  = 4'd6;
      go = 1'b1;
      tick();                                   // edge 1
      tick();                                   // edge 2: operands captured
      x  = 4'd1;
      y  = 4'd1;
      tick();
      tick();
      tick();
      check("hold busy e5", 16'(busy), 16'd1);
      tick();                                   // edge 6
      check("hold p", 16'(p), 16'h2A);
      check("hold done", 16'(done), 16'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold stay done", 16'(done), 16'd1);
         check("hold no busy", 16'(busy), 16'd0);
         check("hold stay p", 16'(p), 16'h2A);
      end
      go = 1'b0;
      tick();
      check("hold release done", 16'(done), 16'd0);
      check("hold release p", 16'(p), 16'h2A);
      exp_p = 8'h2A;

      // 6. reset during the second CALC cycle
      x  = 4'hF;
      y  = 4'hF;
      go = 1'b1;
      tick();                                   // edge 1 -> LOAD
      go = 1'b0;
      tick();                                   // edge 2 -> CALC
      tick();                                   // edge 3: first CALC cycle
      rst = 1'b0;
      tick();                                   // edge 4: reset wins
      check("midrst p", 16'(p), 16'h00);
      check("midrst done", 16'(done), 16'd0);
      check("midrst busy", 16'(busy), 16'd0);
      rst = 1'b1;
      exp_p = '0;
      tick();
      check("post rst idle", 16'(busy), 16'd0);
      run_op("2x4", 4'd2, 4'd4, 8'h08);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
